icache_refill_unit: RTL and testbench
=====================================

# icache_refill_unit

Converts a single ICache line-miss request into one AXI4 INCR read burst. Assembles the returned beats into a line buffer and hands the full line back to the ICache. It sits between the ICache miss path and the icache AXI4 master port that feeds slave 0 of the core's 2x1 AXI interconnect. The block is read-only, and the write channels are tied off.

## Interface
Parameters:
- LINE_WORDS, 4: 32-bit words per cache line; a power of two, 2..16.
- AXI_ID, 0: constant ar_id value, 4 bits wide.

Ports:
- clk  in  1  core clock.
- a_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  miss request valid.
- req_ready  out  1  block can accept a request.
- req_paddr  in  `PROC_PALEN  miss physical address; offset bits are ignored.
- req_uncached  in  1  single-word uncached fetch (ICACHE_REFILL_UNCACHED_EN only).
- resp_valid  out  1  line (or word) ready.
- resp_ready  in  1  ICache consumes the response.
- resp_data  out  LINE_WORDS*32  line data; word i is at bits [32i+31:32i].
- resp_err  out  1  any beat had r_resp[1] set (SLVERR or DECERR).
- axi4_mst  AXI4.Master  32-bit data, 4-bit ID, 1-bit user; connects to the icache master.

## Operation
FSM states: IDLE, AR, R, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid: latch the aligned address, clear resp_err, clear the beat count, go to AR.
- **AR**
  - ar_valid=1.
  - ar_addr = {req_paddr[PALEN-1:OFF], OFF'b0}, where OFF = log2(LINE_WORDS*4).
  - ar_len = LINE_WORDS-1; ar_size = 3'b010; ar_burst = 2'b01.
  - ar_id = AXI_ID; ar_cache = 4'b0000; ar_lock, ar_prot, ar_qos, ar_user = 0.
  - ar_valid and all AR fields stay stable until ar_ready; on handshake go to R.
- **R**
  - r_ready=1.
  - Each r_valid beat writes r_data into word[beat_cnt], then beat_cnt++.
  - resp_err |= r_resp[1].
  - On the beat with r_last: go to RESP.
  - beat_cnt is log2(LINE_WORDS) bits wide and wraps. The line is considered complete on r_last regardless of count.
  - r_id is ignored; the interconnect keeps only one burst outstanding per master.
- **RESP**
  - resp_valid=1; resp_data and resp_err are held stable.
  - On resp_ready: go to IDLE.
- Write channels are tied off: aw_valid=0, w_valid=0, b_ready=1, and all AW/W fields are 0.

## Timing
- Reset values of every output:
  - req_ready=1 (state IDLE).
  - resp_valid=0, resp_err=0, resp_data=0.
  - ar_valid=0, r_ready=0.
- Request accepted in cycle 0 → ar_valid is asserted in cycle 1 (registered).
- The first beat can be accepted in the cycle after the AR handshake.
- resp_valid rises in the cycle after the r_last beat.
- Minimum miss-to-response latency is 3+LINE_WORDS cycles with zero-wait AXI.
- All outputs come from registers or the state register. There is no combinational path from r_valid to resp_valid, or from resp_ready to req_ready.
- req_ready=1 only in IDLE, so back-to-back requests cost one IDLE cycle after the response handshake.
- Reset mid-burst returns to IDLE immediately and the outstanding burst is abandoned. The interconnect shares a_rst_n, so no orphaned beats arrive.
- Early r_last (fewer beats than LINE_WORDS): unwritten words keep stale data and resp_err is forced to 1.

## Configuration
ICACHE_REFILL_UNCACHED_EN:
- **Defined:**
  - The req_uncached port exists.
  - An uncached request issues ar_len=0 and ar_addr = {req_paddr[PALEN-1:2], 2'b00}.
  - The single beat is written to word[req_paddr[OFF-1:2]], so the ICache reads it at its normal offset.
- **Undefined:**
  - The port is absent and every request is a full-line burst.

## Structure
- Shared package (core-wide defines, alongside the decoder/config definitions):
  - ICache line geometry constants (line words, offset width).
  - Refill FSM state enum.
  - AXI burst/size/resp localparams (INCR, SIZE_4B, SLVERR bit).
- No sub-module needed. The line buffer is a flat register array inside the block.

## Test plan
- **Zero-wait line refill:** req_paddr=0x1C00_0014, LINE_WORDS=4, slave returns 0xA0..0xA3 → ar_addr=0x1C00_0010, ar_len=3; resp_valid 7 cycles after acceptance; resp_data words {A3,A2,A1,A0}; resp_err=0.
- **Backpressure on all channels:** ar_ready held 0 for 5 cycles, then r_valid gaps of 2 cycles between beats, then resp_ready held 0 for 4 cycles → AR fields stable during the stall; all 4 words correct; resp_valid held until resp_ready.
- **Error response:** beat 2 returns r_resp=2'b10 → all 4 beats still accepted; resp_err=1.
- **Early r_last:** r_last on beat 1 → RESP entered; resp_err=1; the FSM returns to IDLE after resp_ready.
- **Reset mid-burst:** a_rst_n low after beat 1 → next cycle state IDLE, req_ready=1, ar_valid=0, r_ready=0, resp_valid=0.
- **Uncached fetch (with macro):** req_uncached=1, paddr=0x1FD0_0008 → ar_len=0, ar_addr=0x1FD0_0008; data lands in word 2; resp_valid 4 cycles after acceptance.

Source files
------------

// File: rtl/icache_refill_unit_pkg.sv
// Shared ICache refill definitions: line geometry, refill FSM states and AXI encodings.
// PROC_PALEN sets the physical address width core-wide (32 when not defined elsewhere).
`ifndef PROC_PALEN
`define PROC_PALEN 32
`endif

package icache_refill_unit_pkg;

   localparam int PALEN             = `PROC_PALEN;
   localparam int ICACHE_LINE_WORDS = 4;
   localparam int ICACHE_OFF_W      = $clog2(ICACHE_LINE_WORDS * 4);

   localparam logic [1:0] AXI_BURST_INCR      = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B         = 3'b010;
   localparam int         AXI_RESP_SLVERR_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_RESP = 2'd3
   } refill_state_e;

   // SLVERR and DECERR both carry bit 1 of the response code.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp[AXI_RESP_SLVERR_BIT];
   endfunction

endpackage

// File: rtl/icache_refill_unit.sv
// ICache miss refill: one AXI4 INCR read burst per miss, assembled into a line buffer.
// Optional single-word uncached fetch is enabled by defining ICACHE_REFILL_UNCACHED_EN.
module icache_refill_unit
   import icache_refill_unit_pkg::*;
#(
   parameter int         LINE_WORDS = ICACHE_LINE_WORDS,
   parameter logic [3:0] AXI_ID     = 4'd0
) (
   input  logic                    i_clk,
   input  logic                    i_a_rst_n,
   // ICache miss request / line response
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic [PALEN-1:0]        i_req_paddr,
`ifdef ICACHE_REFILL_UNCACHED_EN
   input  logic                    i_req_uncached,
`endif
   output logic                    o_resp_valid,
   input  logic                    i_resp_ready,
   output logic [LINE_WORDS*32-1:0] o_resp_data,
   output logic                    o_resp_err,
   // AXI4 read address channel
   output logic                    o_axi_ar_valid,
   input  logic                    i_axi_ar_ready,
   output logic [3:0]              o_axi_ar_id,
   output logic [PALEN-1:0]        o_axi_ar_addr,
   output logic [7:0]              o_axi_ar_len,
   output logic [2:0]              o_axi_ar_size,
   output logic [1:0]              o_axi_ar_burst,
   output logic                    o_axi_ar_lock,
   output logic [3:0]              o_axi_ar_cache,
   output logic [2:0]              o_axi_ar_prot,
   output logic [3:0]              o_axi_ar_qos,
   output logic                    o_axi_ar_user,
   // AXI4 read data channel
   input  logic                    i_axi_r_valid,
   output logic                    o_axi_r_ready,
   input  logic [3:0]              i_axi_r_id,
   input  logic [31:0]             i_axi_r_data,
   input  logic [1:0]              i_axi_r_resp,
   input  logic                    i_axi_r_last,
   input  logic                    i_axi_r_user,
   // AXI4 write address channel (tied off)
   output logic                    o_axi_aw_valid,
   input  logic                    i_axi_aw_ready,
   output logic [3:0]              o_axi_aw_id,
   output logic [PALEN-1:0]        o_axi_aw_addr,
   output logic [7:0]              o_axi_aw_len,
   output logic [2:0]              o_axi_aw_size,
   output logic [1:0]              o_axi_aw_burst,
   output logic                    o_axi_aw_lock,
   output logic [3:0]              o_axi_aw_cache,
   output logic [2:0]              o_axi_aw_prot,
   output logic [3:0]              o_axi_aw_qos,
   output logic                    o_axi_aw_user,
   // AXI4 write data channel (tied off)
   output logic                    o_axi_w_valid,
   input  logic                    i_axi_w_ready,
   output logic [31:0]             o_axi_w_data,
   output logic [3:0]              o_axi_w_strb,
   output logic                    o_axi_w_last,
   output logic                    o_axi_w_user,
   // AXI4 write response channel (always accepted)
   input  logic                    i_axi_b_valid,
   output logic                    o_axi_b_ready,
   input  logic [3:0]              i_axi_b_id,
   input  logic [1:0]              i_axi_b_resp,
   input  logic                    i_axi_b_user
);

   localparam int OFF   = $clog2(LINE_WORDS * 4);
   localparam int CNT_W = $clog2(LINE_WORDS);

   refill_state_e             r_state;
   refill_state_e             w_state_nxt;
   logic [PALEN-1:0]          r_ar_addr;
   logic [7:0]                r_ar_len;
   logic [CNT_W-1:0]          r_beat_cnt;
   logic [LINE_WORDS*32-1:0]  r_line;
   logic                      r_err;

   logic [PALEN-1:0]          w_req_addr;
   logic [7:0]                w_req_len;
   logic [CNT_W-1:0]          w_wr_idx;
   logic [CNT_W-1:0]          w_last_cnt;
   logic                      w_unused;

`ifdef ICACHE_REFILL_UNCACHED_EN
   logic                      r_uc;
   logic [CNT_W-1:0]          r_uc_idx;

   assign w_req_addr = i_req_uncached ? {i_req_paddr[PALEN-1:2], 2'b00}
                                      : {i_req_paddr[PALEN-1:OFF], {OFF{1'b0}}};
   assign w_req_len  = i_req_uncached ? 8'd0 : 8'(LINE_WORDS - 1);
   // An uncached word lands at its normal line offset so the ICache reads it in place.
   assign w_wr_idx   = r_uc ? r_uc_idx : r_beat_cnt;
   assign w_last_cnt = r_uc ? CNT_W'(0) : CNT_W'(LINE_WORDS - 1);
   assign w_unused   = ^{i_axi_r_id, i_axi_r_user, i_axi_aw_ready, i_axi_w_ready,
                         i_axi_b_valid, i_axi_b_id, i_axi_b_resp, i_axi_b_user,
                         i_req_paddr[1:0]};
`else
   assign w_req_addr = {i_req_paddr[PALEN-1:OFF], {OFF{1'b0}}};
   assign w_req_len  = 8'(LINE_WORDS - 1);
   assign w_wr_idx   = r_beat_cnt;
   assign w_last_cnt = CNT_W'(LINE_WORDS - 1);
   assign w_unused   = ^{i_axi_r_id, i_axi_r_user, i_axi_aw_ready, i_axi_w_ready,
                         i_axi_b_valid, i_axi_b_id, i_axi_b_resp, i_axi_b_user,
                         i_req_paddr[OFF-1:0]};
`endif

   // Refill FSM state register.
   always_ff @(posedge i_clk or negedge i_a_rst_n) begin
      if (!i_a_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Refill FSM next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_req_valid) w_state_nxt = ST_AR;
            else             w_state_nxt = ST_IDLE;
         end
         ST_AR: begin
            if (i_axi_ar_ready) w_state_nxt = ST_R;
            else                w_state_nxt = ST_AR;
         end
         ST_R: begin
            if (i_axi_r_valid && i_axi_r_last) w_state_nxt = ST_RESP;
            else                               w_state_nxt = ST_R;
         end
         ST_RESP: begin
            if (i_resp_ready) w_state_nxt = ST_IDLE;
            else              w_state_nxt = ST_RESP;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Request latch, beat assembly and error accumulation.
   always_ff @(posedge i_clk or negedge i_a_rst_n) begin
      if (!i_a_rst_n) begin
         r_ar_addr  <= '0;
         r_ar_len   <= 8'd0;
         r_beat_cnt <= '0;
         r_line     <= '0;
         r_err      <= 1'b0;
`ifdef ICACHE_REFILL_UNCACHED_EN
         r_uc       <= 1'b0;
         r_uc_idx   <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_req_valid) begin
                  r_ar_addr  <= w_req_addr;
                  r_ar_len   <= w_req_len;
                  r_beat_cnt <= '0;
                  r_err      <= 1'b0;
`ifdef ICACHE_REFILL_UNCACHED_EN
                  r_uc       <= i_req_uncached;
                  r_uc_idx   <= i_req_paddr[OFF-1:2];
`endif
               end
            end
            ST_R: begin
               if (i_axi_r_valid) begin
                  r_line[{w_wr_idx, 5'd0} +: 32] <= i_axi_r_data;
                  r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                  // A short burst leaves stale words behind, so it is reported as an error.
                  r_err <= r_err | resp_is_err(i_axi_r_resp)
                         | (i_axi_r_last && (r_beat_cnt != w_last_cnt));
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_req_ready    = (r_state == ST_IDLE);
   assign o_resp_valid   = (r_state == ST_RESP);
   assign o_resp_data    = r_line;
   assign o_resp_err     = r_err;

   assign o_axi_ar_valid = (r_state == ST_AR);
   assign o_axi_ar_id    = AXI_ID;
   assign o_axi_ar_addr  = r_ar_addr;
   assign o_axi_ar_len   = r_ar_len;
   assign o_axi_ar_size  = AXI_SIZE_4B;
   assign o_axi_ar_burst = AXI_BURST_INCR;
   assign o_axi_ar_lock  = 1'b0;
   assign o_axi_ar_cache = 4'b0000;
   assign o_axi_ar_prot  = 3'b000;
   assign o_axi_ar_qos   = 4'b0000;
   assign o_axi_ar_user  = 1'b0;
   assign o_axi_r_ready  = (r_state == ST_R);

   assign o_axi_aw_valid = 1'b0;
   assign o_axi_aw_id    = 4'd0;
   assign o_axi_aw_addr  = '0;
   assign o_axi_aw_len   = 8'd0;
   assign o_axi_aw_size  = 3'd0;
   assign o_axi_aw_burst = 2'd0;
   assign o_axi_aw_lock  = 1'b0;
   assign o_axi_aw_cache = 4'd0;
   assign o_axi_aw_prot  = 3'd0;
   assign o_axi_aw_qos   = 4'd0;
   assign o_axi_aw_user  = 1'b0;
   assign o_axi_w_valid  = 1'b0;
   assign o_axi_w_data   = 32'd0;
   assign o_axi_w_strb   = 4'd0;
   assign o_axi_w_last   = 1'b0;
   assign o_axi_w_user   = 1'b0;
   assign o_axi_b_ready  = 1'b1;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Self-checking bench for icache_refill_unit: table of refill scenarios driven against a
// scripted AXI slave, line/err results checked through a scoreboard queue.
module tb_icache_refill_unit;

   localparam int         LW    = 4;
   localparam logic [3:0] TB_ID = 4'h5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          i_a_rst_n;
   logic          i_req_valid, o_req_ready, i_req_uncached;
   logic [31:0]   i_req_paddr;
   logic          o_resp_valid, i_resp_ready, o_resp_err;
   logic [127:0]  o_resp_data;
   logic          o_ar_valid, i_ar_ready, o_ar_lock, o_ar_user;
   logic [3:0]    o_ar_id, o_ar_cache, o_ar_qos;
   logic [31:0]   o_ar_addr;
   logic [7:0]    o_ar_len;
   logic [2:0]    o_ar_size, o_ar_prot;
   logic [1:0]    o_ar_burst;
   logic          i_r_valid, o_r_ready, i_r_last;
   logic [31:0]   i_r_data;
   logic [1:0]    i_r_resp;
   logic          o_aw_valid, o_aw_lock, o_aw_user;
   logic [3:0]    o_aw_id, o_aw_cache, o_aw_qos;
   logic [31:0]   o_aw_addr;
   logic [7:0]    o_aw_len;
   logic [2:0]    o_aw_size, o_aw_prot;
   logic [1:0]    o_aw_burst;
   logic          o_w_valid, o_w_last, o_w_user, o_b_ready;
   logic [31:0]   o_w_data;
   logic [3:0]    o_w_strb;

   icache_refill_unit #(.LINE_WORDS(LW), .AXI_ID(TB_ID)) dut (
      .i_clk(clk), .i_a_rst_n(i_a_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_paddr(i_req_paddr),
`ifdef ICACHE_REFILL_UNCACHED_EN
      .i_req_uncached(i_req_uncached),
`endif
      .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
      .o_resp_data(o_resp_data), .o_resp_err(o_resp_err),
      .o_axi_ar_valid(o_ar_valid), .i_axi_ar_ready(i_ar_ready), .o_axi_ar_id(o_ar_id),
      .o_axi_ar_addr(o_ar_addr), .o_axi_ar_len(o_ar_len), .o_axi_ar_size(o_ar_size),
      .o_axi_ar_burst(o_ar_burst), .o_axi_ar_lock(o_ar_lock), .o_axi_ar_cache(o_ar_cache),
      .o_axi_ar_prot(o_ar_prot), .o_axi_ar_qos(o_ar_qos), .o_axi_ar_user(o_ar_user),
      .i_axi_r_valid(i_r_valid), .o_axi_r_ready(o_r_ready), .i_axi_r_id(TB_ID),
      .i_axi_r_data(i_r_data), .i_axi_r_resp(i_r_resp), .i_axi_r_last(i_r_last),
      .i_axi_r_user(1'b0),
      .o_axi_aw_valid(o_aw_valid), .i_axi_aw_ready(1'b0), .o_axi_aw_id(o_aw_id),
      .o_axi_aw_addr(o_aw_addr), .o_axi_aw_len(o_aw_len), .o_axi_aw_size(o_aw_size),
      .o_axi_aw_burst(o_aw_burst), .o_axi_aw_lock(o_aw_lock), .o_axi_aw_cache(o_aw_cache),
      .o_axi_aw_prot(o_aw_prot), .o_axi_aw_qos(o_aw_qos), .o_axi_aw_user(o_aw_user),
      .o_axi_w_valid(o_w_valid), .i_axi_w_ready(1'b0), .o_axi_w_data(o_w_data),
      .o_axi_w_strb(o_w_strb), .o_axi_w_last(o_w_last), .o_axi_w_user(o_w_user),
      .i_axi_b_valid(1'b0), .o_axi_b_ready(o_b_ready), .i_axi_b_id(4'd0),
      .i_axi_b_resp(2'd0), .i_axi_b_user(1'b0)
   );

   typedef struct {
      logic [31:0] paddr;
      logic        uc;
      logic [31:0] exp_addr;
      logic [7:0]  exp_len;
      int          ar_stall;
      int          r_gap;
      int          resp_stall;
      int          err_beat;
      int          last_beat;
      logic [31:0] base;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [127:0] line;
      logic         err;
   } sb_t;

`ifdef ICACHE_REFILL_UNCACHED_EN
   localparam int NV = 6;
`else
   localparam int NV = 5;
`endif

   vec_t        vt [NV];
   sb_t         sb_q [$];
   logic [31:0] model_line [LW];
   int          n_err = 0;
   int          n_chk = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] pack_model();
      logic [127:0] p;
      for (int i = 0; i < LW; i++) p[32*i +: 32] = model_line[i];
      return p;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < LW; i++) model_line[i] = 32'd0;
   endtask

   // rst_after >= 0 pulls reset right after that beat and abandons the burst.
   task automatic run_vec(input vec_t v, input int rst_after);
      int  cyc;
      int  nb;
      int  idx;
      sb_t e;
      sb_t got;
      nb = v.uc ? 1 : v.last_beat + 1;
      for (int b = 0; b < nb; b++) begin
         idx = v.uc ? int'(v.paddr[3:2]) : b;
         model_line[idx] = v.base + 32'(b);
      end
      e.line = pack_model();
      e.err  = v.exp_err;
      sb_q.push_back(e);

      @(negedge clk);
      chk("req_ready_idle", o_req_ready, 1'b1);
      i_req_valid    = 1'b1;
      i_req_paddr    = v.paddr;
      i_req_uncached = v.uc;
      cyc = 0;
      @(negedge clk); cyc++;
      i_req_valid    = 1'b0;
      i_req_uncached = 1'b0;
      chk("ar_valid_rise", o_ar_valid, 1'b1);
      chk("req_ready_busy", o_req_ready, 1'b0);
      for (int s = 0; s < v.ar_stall; s++) begin
         @(negedge clk); cyc++;
         chk("ar_valid_stall", o_ar_valid, 1'b1);
         chk("ar_addr_stall", o_ar_addr, v.exp_addr);
         chk("ar_len_stall", o_ar_len, v.exp_len);
      end
      chk("ar_addr", o_ar_addr, v.exp_addr);
      chk("ar_len", o_ar_len, v.exp_len);
      chk("ar_fixed", {o_ar_size, o_ar_burst, o_ar_id, o_ar_cache, o_ar_lock, o_ar_prot,
                       o_ar_qos, o_ar_user}, {3'b010, 2'b01, TB_ID, 4'd0, 1'b0, 3'd0, 4'd0, 1'b0});
      i_ar_ready = 1'b1;
      @(negedge clk); cyc++;
      i_ar_ready = 1'b0;
      chk("ar_valid_drop", o_ar_valid, 1'b0);

      for (int b = 0; b < nb; b++) begin
         if (b > 0) begin
            for (int g = 0; g < v.r_gap; g++) begin
               @(negedge clk); cyc++;
            end
         end
         i_r_valid = 1'b1;
         i_r_data  = v.base + 32'(b);
         i_r_resp  = (b == v.err_beat) ? 2'b10 : 2'b00;
         i_r_last  = (b == nb - 1);
         chk("r_ready", o_r_ready, 1'b1);
         @(negedge clk); cyc++;
         i_r_valid = 1'b0;
         i_r_last  = 1'b0;
         i_r_resp  = 2'b00;
         if (b == rst_after) begin
            i_a_rst_n = 1'b0;
            #1;
            chk("rst_req_ready", o_req_ready, 1'b1);
            chk("rst_ar_valid", o_ar_valid, 1'b0);
            chk("rst_r_ready", o_r_ready, 1'b0);
            chk("rst_resp_valid", o_resp_valid, 1'b0);
            chk("rst_resp", {o_resp_err, o_resp_data}, 129'd0);
            @(negedge clk);
            i_a_rst_n = 1'b1;
            chk("rst_idle_next", {o_req_ready, o_ar_valid, o_r_ready, o_resp_valid}, 4'b1000);
            clear_model();
            void'(sb_q.pop_back());
            return;
         end
      end

      chk("resp_valid_rise", o_resp_valid, 1'b1);
      // Inclusive count: acceptance cycle through first resp_valid cycle.
      if (v.exp_lat > 0) chk("latency", 128'(cyc + 1), 128'(v.exp_lat));
      for (int s = 0; s < v.resp_stall; s++) begin
         @(negedge clk);
         chk("resp_valid_hold", o_resp_valid, 1'b1);
         chk("resp_data_hold", o_resp_data, e.line);
      end
      i_resp_ready = 1'b1;
      chk("sb_nonempty", 128'(sb_q.size() > 0), 128'd1);
      if (sb_q.size() > 0) begin
         got = sb_q.pop_front();
         chk("resp_data", o_resp_data, got.line);
         chk("resp_err", o_resp_err, got.err);
      end
      @(negedge clk);
      i_resp_ready = 1'b0;
      chk("resp_valid_drop", o_resp_valid, 1'b0);
      chk("req_ready_back", o_req_ready, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      vt[0] = '{32'h1C00_0014, 1'b0, 32'h1C00_0010, 8'd3, 0, 0, 0, -1, 3, 32'h0000_00A0, 1'b0, 7};
      vt[1] = '{32'h2000_123C, 1'b0, 32'h2000_1230, 8'd3, 5, 2, 4, -1, 3, 32'h0000_00B0, 1'b0, -1};
      vt[2] = '{32'h8000_0004, 1'b0, 32'h8000_0000, 8'd3, 0, 0, 0,  2, 3, 32'h0000_00C0, 1'b1, 7};
      vt[3] = '{32'h0000_00FC, 1'b0, 32'h0000_00F0, 8'd3, 0, 0, 0, -1, 1, 32'h0000_00D0, 1'b1, -1};
      vt[4] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFF0, 8'd3, 1, 1, 1, -1, 3, 32'h1234_5670, 1'b0, -1};
`ifdef ICACHE_REFILL_UNCACHED_EN
      vt[5] = '{32'h1FD0_0008, 1'b1, 32'h1FD0_0008, 8'd0, 0, 0, 0, -1, 0, 32'h0000_00E0, 1'b0, 4};
`endif

      i_a_rst_n = 1'b0;
      i_req_valid = 1'b0; i_req_paddr = 32'd0; i_req_uncached = 1'b0;
      i_resp_ready = 1'b0; i_ar_ready = 1'b0;
      i_r_valid = 1'b0; i_r_data = 32'd0; i_r_resp = 2'b00; i_r_last = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      chk("reset_handshake", {o_req_ready, o_resp_valid, o_ar_valid, o_r_ready}, 4'b1000);
      chk("reset_resp", {o_resp_err, o_resp_data}, 129'd0);
      chk("write_tieoff", {o_aw_valid, o_w_valid, o_b_ready}, 3'b001);
      chk("write_fields", {o_aw_id, o_aw_addr, o_aw_len, o_aw_size, o_aw_burst, o_aw_lock,
                           o_aw_cache, o_aw_prot, o_aw_qos, o_aw_user, o_w_data, o_w_strb,
                           o_w_last, o_w_user}, 128'd0);
      i_a_rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(vt[i], -1);

      rv = vt[0];
      rv.base = 32'h0000_0770;
      run_vec(rv, 1);
      run_vec(vt[1], -1);

      chk("sb_drained", 128'(sb_q.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
